// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port word memory (fetch = m0, data = m1).
// Define MEM_ARB_FIXED_PRIO_EN to give m1 fixed priority instead of round-robin.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          txn_id_q, txn_id_d;
  logic          txn_we_q, txn_we_d;
  logic [AW-1:0] txn_addr_q, txn_addr_d;
  logic [DW-1:0] txn_wdata_q, txn_wdata_d;
  logic          last_gnt_q, last_gnt_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic any_req;
  logic winner;

  // Winner id: 0 selects m0, 1 selects m1.
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      winner = 1'b1;
`else
      winner = ~last_gnt_q;
`endif
    end else begin
      winner = m1_req;
    end
  end

  always_comb begin
    state_d     = state_q;
    txn_id_d    = txn_id_q;
    txn_we_d    = txn_we_q;
    txn_addr_d  = txn_addr_q;
    txn_wdata_d = txn_wdata_q;
    last_gnt_d  = last_gnt_q;
    rdata_d     = rdata_q;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          m0_gnt      = ~winner;
          m1_gnt      = winner;
          txn_id_d    = winner;
          txn_we_d    = winner ? m1_we    : m0_we;
          txn_addr_d  = winner ? m1_addr  : m0_addr;
          txn_wdata_d = winner ? m1_wdata : m0_wdata;
          last_gnt_d  = winner;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        mem_we  = txn_we_q;
        // Combinational read sees pre-write contents on a write cycle.
        rdata_d = mem_rdata;
        state_d = StResp;
      end
      StResp: begin
        m0_rvalid = ~txn_id_q;
        m1_rvalid = txn_id_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset kills the in-flight transaction in the same cycle, including its write.
    if (reset) begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      txn_id_q    <= 1'b0;
      txn_we_q    <= 1'b0;
      txn_addr_q  <= '0;
      txn_wdata_q <= '0;
      last_gnt_q  <= 1'b1;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      txn_id_q    <= txn_id_d;
      txn_we_q    <= txn_we_d;
      txn_addr_q  <= txn_addr_d;
      txn_wdata_q <= txn_wdata_d;
      last_gnt_q  <= last_gnt_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_addr  = txn_addr_q;
  assign mem_wdata = txn_wdata_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, reference memory and response scoreboard.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [32:0] sb [$];

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(
    .AW(32),
    .DW(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit id, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (id) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end
  endtask

  // Starts just after a rising edge; returns at the falling edge of the RESP cycle.
  task automatic issue(input bit id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, output int waited);
    logic [31:0] a;
    a = addr;
    drive(id, 1'b1, we, addr, wd);
    waited = 0;
    @(negedge clk);
    while (!(id ? m1_gnt : m0_gnt) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      check("gnt_timeout", 64'(1), 64'(0));
      drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
      return;
    end
    check("gnt_other", 64'(id ? m0_gnt : m1_gnt), 64'(0));
    check("idle_we", 64'(mem_we), 64'(0));
    sb.push_back({id, ref_mem[a[7:2]]});
    if (we) ref_mem[a[7:2]] = wd;
    @(posedge clk);
    #1 drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("acc_we", 64'(mem_we), 64'(we));
    check("acc_addr", 64'(mem_addr), 64'(addr));
    if (we) check("acc_wdata", 64'(mem_wdata), 64'(wd));
    @(negedge clk);
    check("resp_rvalid", 64'(id ? m1_rvalid : m0_rvalid), 64'(1));
    check("resp_we", 64'(mem_we), 64'(0));
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      check("gnt_excl", 64'(m0_gnt & m1_gnt), 64'(0));
      check("rv_excl", 64'(m0_rvalid & m1_rvalid), 64'(0));
      if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) begin
          check("rv_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("rv_id", 64'(m1_rvalid), 64'(e[32]));
          check("rv_data", 64'(m1_rvalid ? m1_rdata : m0_rdata), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int w;
    bit exp_id;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[2]  = 32'h5A5A0002; ref_mem[2]  = 32'h5A5A0002;
    mem[4]  = 32'hDEADBEEF; ref_mem[4]  = 32'hDEADBEEF;
    mem[8]  = 32'h0BADF00D; ref_mem[8]  = 32'h0BADF00D;
    mem[12] = 32'hAAAA5555; ref_mem[12] = 32'hAAAA5555;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
    check("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(0));
    check("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'(0));
    check("rst_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Single m0 read.
    issue(1'b0, 1'b0, 32'h10, 32'h0, w);
    check("rd_first_wait", 64'(w), 64'(0));

    // m1 write returns the old contents, then m0 reads back the new word.
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 32'h20, 32'h12345678, w);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'h20, 32'h0, w);

    // Request arriving in RESP waits for the next IDLE.
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h10, 32'h0, w);
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    #1 check("resp_no_gnt", 64'(m0_gnt | m1_gnt), 64'(0));
    issue(1'b0, 1'b0, 32'h8, 32'h0, w);
    check("resp_gnt_next", 64'(w), 64'(0));

    // Reset during the ACCESS cycle of an m1 write cancels it.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 32'h30, 32'h11112222);
    @(negedge clk);
    check("rst_txn_gnt", 64'(m1_gnt), 64'(1));
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1 check("rst_acc_we", 64'(mem_we), 64'(0));
    @(negedge clk);
    check("rst_acc_rv", 64'({m0_rvalid, m1_rvalid}), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 issue(1'b0, 1'b0, 32'h30, 32'h0, w);

    // Idle bus.
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_quiet", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we}), 64'(0));
    end
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h8, 32'h0, w);
    check("idle_then_gnt", 64'(w), 64'(0));

    // Continuous contention from reset.
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 12; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_id = 1'b1;
`else
      exp_id = ((k / 3) % 2) != 0;
`endif
      @(negedge clk);
      if (k % 3 == 0) begin
        check("cont_gnt0", 64'(m0_gnt), 64'(!exp_id));
        check("cont_gnt1", 64'(m1_gnt), 64'(exp_id));
        sb.push_back({exp_id, exp_id ? ref_mem[8] : ref_mem[4]});
      end else begin
        check("cont_nognt", 64'(m0_gnt | m1_gnt), 64'(0));
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);

    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
